// File: rtl/ofdm_symbol_sched.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_symbol_sched
// Description : QPSK subcarrier scheduler with pilots, guard gaps and framing.
//               Optional payload scrambling enabled by defining QPSK_SCRAMBLER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ofdm_symbol_sched #(
    parameter int N_SUB         = 64,
    parameter int PILOT_SPACING = 8,
    parameter int GUARD_LEN     = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] n_symbols,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] sym_i,
    output logic [1:0] sym_q,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       sym_first,
    output logic       sym_last,
    output logic       sym_pilot,
    output logic       busy,
    output logic       done
);

    localparam int              c_KW     = $clog2(N_SUB);
    localparam int              c_GW     = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(N_SUB - 1);
    localparam logic [c_KW-1:0] c_PMASK  = c_KW'(PILOT_SPACING - 1);
    localparam logic [c_GW-1:0] c_G_LAST = c_GW'(GUARD_LEN - 1);
    localparam logic [1:0]      c_POS    = 2'b01;
    localparam logic [1:0]      c_NEG    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SLOT  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [c_KW-1:0] r_k_q, w_k_d;
    logic [c_GW-1:0] r_gcnt_q, w_gcnt_d;
    logic [7:0]      r_nsym_q, w_nsym_d;
    logic [7:0]      r_buf_q, w_buf_d;
    logic [2:0]      r_cnt_q, w_cnt_d;
    logic            r_in_ready_q, w_in_ready_d;
    logic [1:0]      r_sym_i_q, w_sym_i_d;
    logic [1:0]      r_sym_q_q, w_sym_q_d;
    logic            r_sym_valid_q, w_sym_valid_d;
    logic            r_sym_first_q, w_sym_first_d;
    logic            r_sym_last_q, w_sym_last_d;
    logic            r_sym_pilot_q, w_sym_pilot_d;
    logic            r_busy_q, w_busy_d;
    logic            r_done_q, w_done_d;

    logic            w_acc;
    logic            w_try;
    logic [c_KW-1:0] w_load_k;
    logic            w_bit_i;
    logic            w_bit_q;

`ifdef QPSK_SCRAMBLER_EN
    logic [6:0] r_lfsr_q, w_lfsr_d;
    logic [6:0] w_lfsr_mid;
    logic       w_prbs0;
    logic       w_prbs1;

    // Two LFSR steps per dibit: the first covers the I bit, the second the Q bit.
    assign w_prbs0    = r_lfsr_q[6] ^ r_lfsr_q[3];
    assign w_lfsr_mid = {r_lfsr_q[5:0], w_prbs0};
    assign w_prbs1    = w_lfsr_mid[6] ^ w_lfsr_mid[3];
    assign w_bit_i    = r_buf_q[0] ^ w_prbs0;
    assign w_bit_q    = r_buf_q[1] ^ w_prbs1;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_lfsr_q <= 7'h7F;
        end else begin
            r_lfsr_q <= w_lfsr_d;
        end
    end
`else
    assign w_bit_i = r_buf_q[0];
    assign w_bit_q = r_buf_q[1];
`endif

    assign w_acc = r_sym_valid_q & sym_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_k_d         = r_k_q;
        w_gcnt_d      = r_gcnt_q;
        w_nsym_d      = r_nsym_q;
        w_buf_d       = r_buf_q;
        w_cnt_d       = r_cnt_q;
        w_sym_i_d     = r_sym_i_q;
        w_sym_q_d     = r_sym_q_q;
        w_sym_valid_d = r_sym_valid_q;
        w_sym_first_d = r_sym_first_q;
        w_sym_last_d  = r_sym_last_q;
        w_sym_pilot_d = r_sym_pilot_q;
        w_done_d      = 1'b0;
        w_try         = 1'b0;
        w_load_k      = r_k_q;
`ifdef QPSK_SCRAMBLER_EN
        w_lfsr_d      = r_lfsr_q;
`endif

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_SLOT;
                    w_k_d     = '0;
                    w_nsym_d  = (n_symbols == 8'd0) ? 8'd1 : n_symbols;
                    w_try     = 1'b1;
                    w_load_k  = '0;
                end
            end
            S_SLOT: begin
                if (w_acc) begin
                    w_sym_valid_d = 1'b0;
                    w_sym_i_d     = 2'b00;
                    w_sym_q_d     = 2'b00;
                    w_sym_first_d = 1'b0;
                    w_sym_last_d  = 1'b0;
                    w_sym_pilot_d = 1'b0;
                    if (r_k_q == c_K_LAST) begin
                        if (r_nsym_q <= 8'd1) begin
                            w_state_d = S_IDLE;
                            w_nsym_d  = 8'd0;
                            w_done_d  = 1'b1;
                        end else begin
                            w_state_d = S_GUARD;
                            w_nsym_d  = r_nsym_q - 8'd1;
                            w_gcnt_d  = '0;
                        end
                    end else begin
                        w_k_d    = r_k_q + c_KW'(1);
                        w_try    = 1'b1;
                        w_load_k = r_k_q + c_KW'(1);
                    end
                end else if (!r_sym_valid_q) begin
                    w_try    = 1'b1;
                    w_load_k = r_k_q;
                end
            end
            S_GUARD: begin
                // Preload subcarrier 0 on the last guard cycle so the gap is exactly GUARD_LEN.
                if (r_gcnt_q == c_G_LAST) begin
                    w_state_d = S_SLOT;
                    w_k_d     = '0;
                    w_try     = 1'b1;
                    w_load_k  = '0;
                end else begin
                    w_gcnt_d = r_gcnt_q + c_GW'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // in_ready is only raised while the buffer is empty, so accept and consume never overlap.
        if (in_valid && r_in_ready_q) begin
            w_buf_d = in_data;
            w_cnt_d = 3'd4;
        end

        if (w_try) begin
            if ((w_load_k & c_PMASK) == '0) begin
                w_sym_valid_d = 1'b1;
                w_sym_i_d     = c_POS;
                w_sym_q_d     = c_POS;
                w_sym_pilot_d = 1'b1;
                w_sym_first_d = (w_load_k == '0);
                w_sym_last_d  = (w_load_k == c_K_LAST);
`ifdef QPSK_SCRAMBLER_EN
                if (w_load_k == '0) begin
                    w_lfsr_d = 7'h7F;
                end
`endif
            end else if (r_cnt_q != 3'd0) begin
                w_sym_valid_d = 1'b1;
                w_sym_i_d     = w_bit_i ? c_POS : c_NEG;
                w_sym_q_d     = w_bit_q ? c_POS : c_NEG;
                w_sym_pilot_d = 1'b0;
                w_sym_first_d = 1'b0;
                w_sym_last_d  = (w_load_k == c_K_LAST);
                w_buf_d       = {2'b00, r_buf_q[7:2]};
                w_cnt_d       = r_cnt_q - 3'd1;
`ifdef QPSK_SCRAMBLER_EN
                w_lfsr_d      = {w_lfsr_mid[5:0], w_prbs1};
`endif
            end
        end

        if (w_state_d == S_IDLE) begin
            w_buf_d = 8'd0;
            w_cnt_d = 3'd0;
        end

        w_in_ready_d = (w_state_d != S_IDLE) && (w_cnt_d == 3'd0);
        w_busy_d     = (w_state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state_q     <= S_IDLE;
            r_k_q         <= '0;
            r_gcnt_q      <= '0;
            r_nsym_q      <= 8'd0;
            r_buf_q       <= 8'd0;
            r_cnt_q       <= 3'd0;
            r_in_ready_q  <= 1'b0;
            r_sym_i_q     <= 2'b00;
            r_sym_q_q     <= 2'b00;
            r_sym_valid_q <= 1'b0;
            r_sym_first_q <= 1'b0;
            r_sym_last_q  <= 1'b0;
            r_sym_pilot_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_k_q         <= w_k_d;
            r_gcnt_q      <= w_gcnt_d;
            r_nsym_q      <= w_nsym_d;
            r_buf_q       <= w_buf_d;
            r_cnt_q       <= w_cnt_d;
            r_in_ready_q  <= w_in_ready_d;
            r_sym_i_q     <= w_sym_i_d;
            r_sym_q_q     <= w_sym_q_d;
            r_sym_valid_q <= w_sym_valid_d;
            r_sym_first_q <= w_sym_first_d;
            r_sym_last_q  <= w_sym_last_d;
            r_sym_pilot_q <= w_sym_pilot_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign sym_i     = r_sym_i_q;
    assign sym_q     = r_sym_q_q;
    assign sym_valid = r_sym_valid_q;
    assign sym_first = r_sym_first_q;
    assign sym_last  = r_sym_last_q;
    assign sym_pilot = r_sym_pilot_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;

endmodule
`default_nettype wire
